// File: rtl/ninjin_ddr_burst.sv
`default_nettype none
// ============================================================================
// Module      : ninjin_ddr_burst
// Description : DDR-side burst master sitting behind ninjin_ddr_buf. Each
//               ddr_req command (mode/base/len) is cut into AXI4-subset INCR
//               bursts of at most BURST_MAX beats.
//                 read  (ddr_mode=0): AR/R traffic fills the buf through
//                                     ddr_we / ddr_waddr / ddr_wdata.
//                 write (ddr_mode=1): AW/W/B traffic drains the buf through
//                                     ddr_raddr / ddr_rdata (1-cycle latency).
//               One further command may wait in a 1-deep pending slot; a
//               command arriving while that slot is full is dropped and
//               raises ddr_err.
// Ports       : clk, xrst (async, active-low)
//               command : ddr_req, ddr_mode, ddr_base, ddr_len
//               status  : ddr_busy, ddr_done, ddr_err
//               buf     : ddr_we, ddr_waddr, ddr_wdata, ddr_raddr, ddr_rdata
//               AXI     : m_ar*, m_r*, m_aw*, m_w*, m_b*
// Config      : NINJIN_DDR_RESP_CHECK_EN - non-OKAY rresp/bresp set ddr_err,
//               and ddr_err clears on the next accepted ddr_req.
// Revision    : 1.0 - initial release
// ============================================================================
module ninjin_ddr_burst #(
    parameter int BWIDTH    = 32,
    parameter int MEMSIZE   = 12,
    parameter int LSB       = 2,
    parameter int LWIDTH    = 10,
    parameter int BURST_MAX = 16
) (
    input  logic                   clk,
    input  logic                   xrst,
    input  logic                   ddr_req,
    input  logic                   ddr_mode,
    input  logic [MEMSIZE+LSB-1:0] ddr_base,
    input  logic [LWIDTH-1:0]      ddr_len,
    output logic                   ddr_we,
    output logic [MEMSIZE-1:0]     ddr_waddr,
    output logic [BWIDTH-1:0]      ddr_wdata,
    output logic [MEMSIZE-1:0]     ddr_raddr,
    input  logic [BWIDTH-1:0]      ddr_rdata,
    output logic                   ddr_busy,
    output logic                   ddr_done,
    output logic                   ddr_err,
    output logic [MEMSIZE+LSB-1:0] m_araddr,
    output logic [7:0]             m_arlen,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [BWIDTH-1:0]      m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rlast,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic [MEMSIZE+LSB-1:0] m_awaddr,
    output logic [7:0]             m_awlen,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [BWIDTH-1:0]      m_wdata,
    output logic                   m_wlast,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready
);

    localparam int                c_awidth    = MEMSIZE + LSB;
    localparam int                c_cwidth    = $clog2(BURST_MAX + 1);
    localparam logic [LWIDTH-1:0] c_burst_max = LWIDTH'(BURST_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t                r_state, w_next;

    logic [c_awidth-1:0]   r_addr;       // byte address of the current/next burst
    logic [LWIDTH-1:0]     r_rest;       // beats not yet covered by an address phase
    logic [c_cwidth-1:0]   r_chunk;      // beats in the burst in progress
    logic [c_cwidth-1:0]   r_beat;       // R beats received / W beats sent
    logic [MEMSIZE-1:0]    r_word;       // next buf word to write (read) or fetch (write)
    logic                  r_pend_vld, r_pend_mode;
    logic [c_awidth-1:0]   r_pend_base;
    logic [LWIDTH-1:0]     r_pend_len;
    logic                  r_we;
    logic [MEMSIZE-1:0]    r_waddr;
    logic [BWIDTH-1:0]     r_wdata;
    logic                  r_err;
    // write-side skid FIFO fed by the buf read port
    logic [BWIDTH-1:0]     r_fifo [2];
    logic                  r_wp, r_rp;
    logic [1:0]            r_cnt;
    logic                  r_inflight;   // buf read issued last cycle, data on ddr_rdata now
    logic [c_cwidth-1:0]   r_issued;

    logic                  w_take, w_cmd_mode;
    logic [c_awidth-1:0]   w_cmd_base;
    logic [LWIDTH-1:0]     w_cmd_len;
    logic [c_cwidth-1:0]   w_chunk, w_chunk_m1;
    logic [7:0]            w_axlen;
    logic                  w_r_hs, w_b_hs, w_pop, w_issue, w_beat_last;
    logic [2:0]            w_room;
    logic                  w_in_body, w_to_slot, w_drop, w_err_set, w_err_clr;

    assign w_chunk     = (r_rest > c_burst_max) ? c_cwidth'(BURST_MAX) : r_rest[c_cwidth-1:0];
    assign w_axlen     = 8'(w_chunk) - 8'd1;
    assign w_chunk_m1  = r_chunk - c_cwidth'(1);
    assign w_beat_last = (r_beat == w_chunk_m1);
    assign w_r_hs      = (r_state == S_RDATA) && m_rvalid;
    assign w_b_hs      = (r_state == S_WRESP) && m_bvalid;
    assign w_pop       = m_wvalid && m_wready;
    // A pop this cycle frees a slot in time for the read issued now, which
    // is what keeps the W channel at one beat per cycle.
    assign w_room      = 3'(2'd2 - r_cnt) + 3'(w_pop);
    assign w_issue     = (r_state == S_WDATA) && (r_issued != r_chunk) &&
                         (w_room > 3'(r_inflight));

    assign w_in_body   = (r_state != S_IDLE) && (r_state != S_FIN);
    // In FIN the slot empties this edge, so a simultaneous request refills it.
    assign w_to_slot   = ddr_req && ((w_in_body && !r_pend_vld) || (r_state == S_FIN && r_pend_vld));
    assign w_drop      = ddr_req && w_in_body && r_pend_vld;

`ifdef NINJIN_DDR_RESP_CHECK_EN
    assign w_err_set = w_drop || (w_r_hs && (m_rlast != w_beat_last)) ||
                       (w_r_hs && (m_rresp != 2'b00)) || (w_b_hs && (m_bresp != 2'b00));
    assign w_err_clr = ddr_req && !w_drop;
`else
    logic w_unused;
    assign w_unused  = ^{m_rresp, m_bresp};
    assign w_err_set = w_drop || (w_r_hs && (m_rlast != w_beat_last));
    assign w_err_clr = 1'b0;
`endif

    assign ddr_we    = r_we;
    assign ddr_waddr = r_waddr;
    assign ddr_wdata = r_wdata;
    assign ddr_err   = r_err;
    assign ddr_busy  = (r_state != S_IDLE) || r_pend_vld;
    assign ddr_raddr = (r_state == S_WDATA) ? r_word : '0;
    assign m_araddr  = r_addr;
    assign m_awaddr  = r_addr;
    assign m_wvalid  = (r_state == S_WDATA) && (r_cnt != 2'd0);
    assign m_wdata   = r_fifo[r_rp];
    assign m_wlast   = m_wvalid && w_beat_last;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_cmd_mode = ddr_mode;
        w_cmd_base = ddr_base;
        w_cmd_len  = ddr_len;
        m_arvalid  = 1'b0;
        m_arlen    = 8'd0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_awlen    = 8'd0;
        m_bready   = 1'b0;
        ddr_done   = 1'b0;
        case (r_state)
            S_IDLE:  w_take = ddr_req;
            S_RADDR: begin
                m_arvalid = 1'b1;
                m_arlen   = w_axlen;
                if (m_arready) w_next = S_RDATA;
            end
            S_RDATA: begin
                m_rready = 1'b1;
                if (w_r_hs && w_beat_last) w_next = (r_rest == '0) ? S_FIN : S_RADDR;
            end
            S_WADDR: begin
                m_awvalid = 1'b1;
                m_awlen   = w_axlen;
                if (m_awready) w_next = S_WDATA;
            end
            S_WDATA: if (w_pop && w_beat_last) w_next = S_WRESP;
            S_WRESP: begin
                m_bready = 1'b1;
                if (m_bvalid) w_next = (r_rest == '0) ? S_FIN : S_WADDR;
            end
            S_FIN: begin
                ddr_done = 1'b1;
                w_next   = S_IDLE;
                if (r_pend_vld) begin
                    w_take     = 1'b1;
                    w_cmd_mode = r_pend_mode;
                    w_cmd_base = r_pend_base;
                    w_cmd_len  = r_pend_len;
                end else begin
                    w_take = ddr_req;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_take) w_next = (w_cmd_len == '0) ? S_FIN : (w_cmd_mode ? S_WADDR : S_RADDR);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_addr      <= '0;
            r_rest      <= '0;
            r_chunk     <= '0;
            r_beat      <= '0;
            r_word      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_mode <= 1'b0;
            r_pend_base <= '0;
            r_pend_len  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= 2'd0;
            r_inflight  <= 1'b0;
            r_issued    <= '0;
        end else begin
            r_we       <= 1'b0;
            r_inflight <= w_issue;

            if (w_to_slot) begin
                r_pend_vld  <= 1'b1;
                r_pend_mode <= ddr_mode;
                r_pend_base <= ddr_base;
                r_pend_len  <= ddr_len;
            end else if (r_state == S_FIN && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            if (w_err_set)      r_err <= 1'b1;
            else if (w_err_clr) r_err <= 1'b0;

            if (w_take) begin
                r_addr <= w_cmd_base;
                r_rest <= w_cmd_len;
                r_word <= w_cmd_base[c_awidth-1:LSB];
            end else if ((r_state == S_RADDR && m_arready) ||
                         (r_state == S_WADDR && m_awready)) begin
                r_chunk    <= w_chunk;
                r_rest     <= r_rest - LWIDTH'(w_chunk);
                r_addr     <= r_addr + (c_awidth'(w_chunk) << LSB);
                r_beat     <= '0;
                r_issued   <= '0;
                r_cnt      <= 2'd0;
                r_wp       <= 1'b0;
                r_rp       <= 1'b0;
                r_inflight <= 1'b0;
            end else if (w_r_hs) begin
                r_we    <= 1'b1;
                r_waddr <= r_word;
                r_wdata <= m_rdata;
                r_word  <= r_word + MEMSIZE'(1);
                r_beat  <= r_beat + c_cwidth'(1);
            end else if (r_state == S_WDATA) begin
                if (w_issue) begin
                    r_word   <= r_word + MEMSIZE'(1);
                    r_issued <= r_issued + c_cwidth'(1);
                end
                if (r_inflight) begin
                    r_fifo[r_wp] <= ddr_rdata;
                    r_wp         <= ~r_wp;
                end
                if (w_pop) begin
                    r_rp   <= ~r_rp;
                    r_beat <= r_beat + c_cwidth'(1);
                end
                r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ninjin_ddr_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_ninjin_ddr_burst
// Description : Directed self-checking bench for ninjin_ddr_burst. A small
//               AXI slave and buf model answer the DUT and log every
//               handshake; the linear stimulus below checks the logs against
//               hand-computed values. Buf word a holds 0xB0000000|a, the k-th
//               R beat after reset carries 0xD0000000+k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ninjin_ddr_burst;

    localparam int MS = 14;
    localparam int AW = MS + 2;

    logic clk, xrst;
    logic ddr_req, ddr_mode;
    logic [AW-1:0] ddr_base;
    logic [9:0] ddr_len;
    logic ddr_we, ddr_busy, ddr_done, ddr_err;
    logic [MS-1:0] ddr_waddr, ddr_raddr;
    logic [31:0] ddr_wdata, ddr_rdata;
    logic [AW-1:0] m_araddr, m_awaddr;
    logic [7:0] m_arlen, m_awlen;
    logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_rdata, m_wdata;
    logic [1:0] m_rresp, m_bresp;

    ninjin_ddr_burst #(.MEMSIZE(MS)) dut (
        .clk(clk), .xrst(xrst), .ddr_req(ddr_req), .ddr_mode(ddr_mode),
        .ddr_base(ddr_base), .ddr_len(ddr_len), .ddr_we(ddr_we),
        .ddr_waddr(ddr_waddr), .ddr_wdata(ddr_wdata), .ddr_raddr(ddr_raddr),
        .ddr_rdata(ddr_rdata), .ddr_busy(ddr_busy), .ddr_done(ddr_done),
        .ddr_err(ddr_err), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave / buf model and logs ----------------
    int cyc = 0;
    logic [8:0]  r_left;
    logic [31:0] r_seq;
    logic        b_pend, wr_tog, wr_mode;
    logic [1:0]  bresp_val;
    int ar_cnt, aw_cnt, we_cnt, w_cnt, done_cnt, r_last_cyc;
    logic [AW-1:0] ar_addr_log [0:15];
    logic [7:0]    ar_len_log  [0:15];
    logic [AW-1:0] aw_addr_log [0:15];
    logic [7:0]    aw_len_log  [0:15];
    int            aw_cyc_log  [0:15];
    logic [MS-1:0] we_addr_log [0:63];
    logic [31:0]   we_data_log [0:63];
    logic [31:0]   w_data_log  [0:63];
    logic          w_last_log  [0:63];
    int            w_cyc_log   [0:63];
    int            done_cyc    [0:3];

    assign m_arready = 1'b1;
    assign m_awready = 1'b1;
    assign m_rvalid  = (r_left != 9'd0);
    assign m_rlast   = (r_left == 9'd1);
    assign m_rdata   = 32'hD000_0000 + r_seq;
    assign m_rresp   = 2'b00;
    assign m_wready  = wr_mode ? wr_tog : 1'b1;
    assign m_bvalid  = b_pend;
    assign m_bresp   = bresp_val;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ddr_rdata <= 32'hB000_0000 | 32'(ddr_raddr);
        if (!xrst) begin
            r_left <= '0; r_seq <= '0; b_pend <= 1'b0; wr_tog <= 1'b0;
            ar_cnt <= 0; aw_cnt <= 0; we_cnt <= 0; w_cnt <= 0; done_cnt <= 0; r_last_cyc <= 0;
        end else begin
            wr_tog <= ~wr_tog;
            if (m_arvalid && m_arready) begin
                if (ar_cnt < 16) begin
                    ar_addr_log[ar_cnt] <= m_araddr;
                    ar_len_log[ar_cnt]  <= m_arlen;
                end
                ar_cnt <= ar_cnt + 1;
                r_left <= {1'b0, m_arlen} + 9'd1;
            end
            if (m_rvalid && m_rready) begin
                r_left <= r_left - 9'd1;
                r_seq  <= r_seq + 32'd1;
                if (r_left == 9'd1) r_last_cyc <= cyc;
            end
            if (m_awvalid && m_awready) begin
                if (aw_cnt < 16) begin
                    aw_addr_log[aw_cnt] <= m_awaddr;
                    aw_len_log[aw_cnt]  <= m_awlen;
                    aw_cyc_log[aw_cnt]  <= cyc;
                end
                aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid && m_wready) begin
                if (w_cnt < 64) begin
                    w_data_log[w_cnt] <= m_wdata;
                    w_last_log[w_cnt] <= m_wlast;
                    w_cyc_log[w_cnt]  <= cyc;
                end
                w_cnt <= w_cnt + 1;
                if (m_wlast) b_pend <= 1'b1;
            end
            if (m_bvalid && m_bready) b_pend <= 1'b0;
            if (ddr_we) begin
                if (we_cnt < 64) begin
                    we_addr_log[we_cnt] <= ddr_waddr;
                    we_data_log[we_cnt] <= ddr_wdata;
                end
                we_cnt <= we_cnt + 1;
            end
            if (ddr_done) begin
                if (done_cnt < 4) done_cyc[done_cnt] <= cyc;
                done_cnt <= done_cnt + 1;
            end
        end
    end

    logic all_zero;
    assign all_zero = ~|{ddr_we, ddr_waddr, ddr_wdata, ddr_raddr, ddr_busy, ddr_done,
                         ddr_err, m_araddr, m_arlen, m_arvalid, m_rready, m_awaddr,
                         m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready};

    // ---------------- checking helpers ----------------
    int n_run, n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // called at a falling edge; returns at the falling edge after capture
    task automatic send_cmd(input logic mode, input logic [AW-1:0] base, input logic [9:0] len);
        ddr_req = 1'b1; ddr_mode = mode; ddr_base = base; ddr_len = len;
        @(negedge clk);
        ddr_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        xrst = 1'b0;
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int n, input string tag);
        for (int i = 0; i < 1000 && done_cnt < n; i++) @(negedge clk);
        check(tag, 64'(done_cnt >= n), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_run = 0; n_fail = 0;
        xrst = 1'b0; ddr_req = 1'b0; ddr_mode = 1'b0; ddr_base = '0; ddr_len = '0;
        wr_mode = 1'b0; bresp_val = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 64'(all_zero), 64'd1);
        xrst = 1'b1;
        @(negedge clk);
        check("idle_not_busy", 64'(ddr_busy), 64'd0);

        // zero-length command: done one cycle after capture, no bus traffic
        send_cmd(1'b0, 16'ha000, 10'd0);
        check("len0_done_pulse", 64'(ddr_done), 64'd1);
        repeat (3) @(negedge clk);
        check("len0_no_ar", 64'(ar_cnt), 64'd0);
        check("len0_done_cnt", 64'(done_cnt), 64'd1);

        // single 16-beat read
        do_reset();
        send_cmd(1'b0, 16'ha000, 10'd16);
        wait_done(1, "t1_done_seen");
        check("t1_ar_cnt", 64'(ar_cnt), 64'd1);
        check("t1_ar_addr", 64'(ar_addr_log[0]), 64'h a000);
        check("t1_ar_len", 64'(ar_len_log[0]), 64'd15);
        check("t1_we_cnt", 64'(we_cnt), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_waddr%0d", i), 64'(we_addr_log[i]), 64'(32'h2800 + i));
            check($sformatf("t1_wdata%0d", i), 64'(we_data_log[i]), 64'(32'hD000_0000 + i));
        end
        check("t1_done_latency", 64'(done_cyc[0] - r_last_cyc), 64'd1);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 40-beat read split into 16/16/8
        do_reset();
        send_cmd(1'b0, 16'ha000, 10'd40);
        wait_done(1, "t2_done_seen");
        check("t2_ar_cnt", 64'(ar_cnt), 64'd3);
        check("t2_ar_addr0", 64'(ar_addr_log[0]), 64'h a000);
        check("t2_ar_addr1", 64'(ar_addr_log[1]), 64'h a040);
        check("t2_ar_addr2", 64'(ar_addr_log[2]), 64'h a080);
        check("t2_ar_len0", 64'(ar_len_log[0]), 64'd15);
        check("t2_ar_len1", 64'(ar_len_log[1]), 64'd15);
        check("t2_ar_len2", 64'(ar_len_log[2]), 64'd7);
        check("t2_we_cnt", 64'(we_cnt), 64'd40);
        for (int i = 0; i < 40; i++)
            check($sformatf("t2_waddr%0d", i), 64'(we_addr_log[i]), 64'(32'h2800 + i));
        check("t2_wdata39", 64'(we_data_log[39]), 64'h D000_0027);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);
        check("t2_idle", 64'(ddr_busy), 64'd0);

        // 8-beat write with wready toggling
        do_reset();
        wr_mode = 1'b1;
        send_cmd(1'b1, 16'ha400, 10'd8);
        wait_done(1, "t3_done_seen");
        check("t3_aw_cnt", 64'(aw_cnt), 64'd1);
        check("t3_aw_addr", 64'(aw_addr_log[0]), 64'h a400);
        check("t3_aw_len", 64'(aw_len_log[0]), 64'd7);
        check("t3_w_cnt", 64'(w_cnt), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_wdata%0d", i), 64'(w_data_log[i]), 64'(32'hB000_2900 + i));
            check($sformatf("t3_wlast%0d", i), 64'(w_last_log[i]), 64'(i == 7));
        end
        check("t3_done_cnt", 64'(done_cnt), 64'd1);

        // same write, wready stuck high: 8 beats back to back
        do_reset();
        wr_mode = 1'b0;
        send_cmd(1'b1, 16'ha400, 10'd8);
        wait_done(1, "t3b_done_seen");
        check("t3b_w_cnt", 64'(w_cnt), 64'd8);
        check("t3b_wdata0", 64'(w_data_log[0]), 64'h B000_2900);
        check("t3b_wdata7", 64'(w_data_log[7]), 64'h B000_2907);
        check("t3b_back_to_back", 64'(w_cyc_log[7] - w_cyc_log[0]), 64'd7);

        // read, queued write, third request dropped
        do_reset();
        send_cmd(1'b0, 16'ha000, 10'd4);
        @(negedge clk);
        send_cmd(1'b1, 16'ha400, 10'd4);
        send_cmd(1'b0, 16'h0000, 10'd1);
        check("t4_drop_err", 64'(ddr_err), 64'd1);
        wait_done(2, "t4_done_seen");
        check("t4_done_cnt", 64'(done_cnt), 64'd2);
        check("t4_ar_cnt", 64'(ar_cnt), 64'd1);
        check("t4_aw_cnt", 64'(aw_cnt), 64'd1);
        check("t4_aw_addr", 64'(aw_addr_log[0]), 64'h a400);
        check("t4_write_after_done", 64'(aw_cyc_log[0] - done_cyc[0]), 64'd1);
        check("t4_we_cnt", 64'(we_cnt), 64'd4);
        check("t4_w_cnt", 64'(w_cnt), 64'd4);
        check("t4_err_sticky", 64'(ddr_err), 64'd1);

        // error write response
        do_reset();
        bresp_val = 2'b10;
        send_cmd(1'b1, 16'ha400, 10'd2);
        wait_done(1, "t5_done_seen");
`ifdef NINJIN_DDR_RESP_CHECK_EN
        check("t5_bresp_err", 64'(ddr_err), 64'd1);
`else
        check("t5_bresp_err", 64'(ddr_err), 64'd0);
`endif
        bresp_val = 2'b00;
        send_cmd(1'b0, 16'h0000, 10'd0);
        check("t5_err_after_req", 64'(ddr_err), 64'd0);

        // asynchronous reset in the middle of a read
        do_reset();
        send_cmd(1'b0, 16'ha000, 10'd16);
        for (int i = 0; i < 200 && we_cnt < 5; i++) @(negedge clk);
        check("t6_reached_beat5", 64'(we_cnt >= 5), 64'd1);
        #2 xrst = 1'b0;
        #1 check("t6_async_zero", 64'(all_zero), 64'd1);
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        send_cmd(1'b0, 16'h0100, 10'd4);
        wait_done(1, "t6_done_seen");
        check("t6_ar_cnt", 64'(ar_cnt), 64'd1);
        check("t6_ar_addr", 64'(ar_addr_log[0]), 64'h0100);
        check("t6_ar_len", 64'(ar_len_log[0]), 64'd3);
        check("t6_we_cnt", 64'(we_cnt), 64'd4);
        check("t6_waddr0", 64'(we_addr_log[0]), 64'h40);
        check("t6_waddr3", 64'(we_addr_log[3]), 64'h43);
        check("t6_wdata0", 64'(we_data_log[0]), 64'h D000_0000);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
